// File: rtl/cpunc_seq_pkg.sv
// Shared types, constants and the byte-strobe helper for the CPUNC AXI sequencer.
package cpunc_seq_pkg;

   localparam int DATA_W = 32;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_CHK,
      ST_AR,
      ST_R,
      ST_AW,
      ST_W,
      ST_AWW,
      ST_B,
      ST_RSP,
      ST_ERR
   } seq_state_e;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10,
      SZ_ILL  = 2'b11
   } seq_size_e;

   // Strobe pattern for the access size moved up to the byte offset; bits shifted past lane 3 are dropped.
   function automatic logic [3:0] lane_strb(input seq_size_e size, input logic [1:0] off);
      logic [3:0] base;
      case (size)
         SZ_BYTE: base = 4'b0001;
         SZ_HALF: base = 4'b0011;
         SZ_WORD: base = 4'b1111;
         default: base = 4'b0000;
      endcase
      return base << off;
   endfunction

endpackage

// File: rtl/cpunc_lane_align.sv
// Byte-lane steering between right-justified core data and the 32-bit AXI data bus.
module cpunc_lane_align
   import cpunc_seq_pkg::*;
(
   input  seq_size_e         size,
   input  logic [1:0]        off,
   input  logic [DATA_W-1:0] wdata,
   input  logic [DATA_W-1:0] axi_rdata,
   output logic [3:0]        wstrb,
   output logic [DATA_W-1:0] axi_wdata,
   output logic [DATA_W-1:0] rdata
);

   always_comb begin
      wstrb     = lane_strb(size, off);
      axi_wdata = wdata << {off, 3'b000};
      case (size)
         SZ_BYTE: rdata = {24'd0, axi_rdata[{off, 3'b000} +: 8]};
         SZ_HALF: rdata = {16'd0, axi_rdata[{off[1], 4'b0000} +: 16]};
         default: rdata = axi_rdata;
      endcase
   end

endmodule

// File: rtl/cpunc_axi_sequencer.sv
// Single-outstanding AXI master turning one core load/store into one single-beat AXI transaction.
// Define CPUNC_SEQ_AWW_PAR_EN to issue AW and W together; otherwise AW strictly precedes W.
module cpunc_axi_sequencer
   import cpunc_seq_pkg::*;
#(
   parameter int AXI_ADDR_WIDTH = 12,
   parameter int AXI_DATA_WIDTH = 32
) (
   input  logic                      CPUNC_ACLK,
   input  logic                      CPUNC_ARESETn,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic                      req_we,
   input  logic [1:0]                req_size,
   input  logic [AXI_ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_W-1:0]         req_wdata,
   output logic                      rsp_valid,
   output logic [DATA_W-1:0]         rsp_rdata,
   output logic                      rsp_err,
   output logic [AXI_ADDR_WIDTH-1:0] CPUNC_AWADDR,
   output logic                      CPUNC_AWVALID,
   input  logic                      CPUNC_AWREADY,
   output logic [AXI_DATA_WIDTH-1:0] CPUNC_WDATA,
   output logic [3:0]                CPUNC_WSTRB,
   output logic                      CPUNC_WVALID,
   output logic                      CPUNC_WLAST,
   input  logic                      CPUNC_WREADY,
   input  logic                      CPUNC_BRESP,
   input  logic                      CPUNC_BVALID,
   output logic                      CPUNC_BREADY,
   output logic [AXI_ADDR_WIDTH-1:0] CPUNC_ARADDR,
   output logic                      CPUNC_ARVALID,
   input  logic                      CPUNC_ARREADY,
   input  logic [AXI_DATA_WIDTH-1:0] CPUNC_RDATA,
   input  logic                      CPUNC_RRESP,
   input  logic                      CPUNC_RVALID,
   output logic                      CPUNC_RREADY
);

   if (AXI_DATA_WIDTH != DATA_W) begin : g_width_check
      $fatal(1, "cpunc_axi_sequencer supports only AXI_DATA_WIDTH = 32");
   end

   seq_state_e                state;
   logic                      we_q;
   seq_size_e                 size_q;
   logic [AXI_ADDR_WIDTH-1:0] addr_q;
   logic [DATA_W-1:0]         wdata_q;
   logic [3:0]                lane_wstrb;
   logic [DATA_W-1:0]         lane_wdata;
   logic [DATA_W-1:0]         lane_rdata;
   logic                      misaligned;
   logic [AXI_ADDR_WIDTH-1:0] word_addr;
   logic                      aw_done;
   logic                      w_done;

   cpunc_lane_align u_lane_align (
      .size      (size_q),
      .off       (addr_q[1:0]),
      .wdata     (wdata_q),
      .axi_rdata (CPUNC_RDATA),
      .wstrb     (lane_wstrb),
      .axi_wdata (lane_wdata),
      .rdata     (lane_rdata)
   );

   assign misaligned = (size_q == SZ_ILL) ||
                       (size_q == SZ_HALF && addr_q[0]) ||
                       (size_q == SZ_WORD && addr_q[1:0] != 2'b00);
   assign word_addr  = {addr_q[AXI_ADDR_WIDTH-1:2], 2'b00};
   // A channel counts as done once its valid has dropped or is being taken this cycle.
   assign aw_done    = !CPUNC_AWVALID || CPUNC_AWREADY;
   assign w_done     = !CPUNC_WVALID || CPUNC_WREADY;
   assign CPUNC_WLAST = CPUNC_WVALID;

   always_ff @(posedge CPUNC_ACLK or negedge CPUNC_ARESETn) begin
      if (!CPUNC_ARESETn) begin
         state         <= ST_IDLE;
         req_ready     <= 1'b1;
         rsp_valid     <= 1'b0;
         rsp_rdata     <= '0;
         rsp_err       <= 1'b0;
         CPUNC_AWADDR  <= '0;
         CPUNC_AWVALID <= 1'b0;
         CPUNC_WDATA   <= '0;
         CPUNC_WSTRB   <= '0;
         CPUNC_WVALID  <= 1'b0;
         CPUNC_BREADY  <= 1'b0;
         CPUNC_ARADDR  <= '0;
         CPUNC_ARVALID <= 1'b0;
         CPUNC_RREADY  <= 1'b0;
         we_q          <= 1'b0;
         size_q        <= SZ_BYTE;
         addr_q        <= '0;
         wdata_q       <= '0;
      end else begin
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_rdata <= '0;
         case (state)
            ST_IDLE: if (req_valid) begin
               req_ready <= 1'b0;
               we_q      <= req_we;
               size_q    <= seq_size_e'(req_size);
               addr_q    <= req_addr;
               wdata_q   <= req_wdata;
               state     <= ST_CHK;
            end
            ST_CHK: begin
               if (misaligned) begin
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b1;
                  state     <= ST_ERR;
               end else if (!we_q) begin
                  CPUNC_ARADDR  <= word_addr;
                  CPUNC_ARVALID <= 1'b1;
                  state         <= ST_AR;
               end else begin
                  CPUNC_AWADDR  <= word_addr;
                  CPUNC_WDATA   <= lane_wdata;
                  CPUNC_WSTRB   <= lane_wstrb;
                  CPUNC_AWVALID <= 1'b1;
`ifdef CPUNC_SEQ_AWW_PAR_EN
                  CPUNC_WVALID  <= 1'b1;
                  state         <= ST_AWW;
`else
                  state         <= ST_AW;
`endif
               end
            end
            ST_AR: if (CPUNC_ARREADY) begin
               CPUNC_ARVALID <= 1'b0;
               CPUNC_RREADY  <= 1'b1;
               state         <= ST_R;
            end
            ST_R: if (CPUNC_RVALID) begin
               CPUNC_RREADY <= 1'b0;
               rsp_valid    <= 1'b1;
               rsp_err      <= CPUNC_RRESP;
               rsp_rdata    <= lane_rdata;
               state        <= ST_RSP;
            end
            ST_AW: if (CPUNC_AWREADY) begin
               CPUNC_AWVALID <= 1'b0;
               CPUNC_WVALID  <= 1'b1;
               state         <= ST_W;
            end
            ST_W: if (CPUNC_WREADY) begin
               CPUNC_WVALID <= 1'b0;
               CPUNC_BREADY <= 1'b1;
               state        <= ST_B;
            end
            ST_AWW: begin
               if (CPUNC_AWREADY) CPUNC_AWVALID <= 1'b0;
               if (CPUNC_WREADY)  CPUNC_WVALID  <= 1'b0;
               if (aw_done && w_done) begin
                  CPUNC_BREADY <= 1'b1;
                  state        <= ST_B;
               end
            end
            ST_B: if (CPUNC_BVALID) begin
               CPUNC_BREADY <= 1'b0;
               rsp_valid    <= 1'b1;
               rsp_err      <= CPUNC_BRESP;
               state        <= ST_RSP;
            end
            default: begin
               req_ready <= 1'b1;
               state     <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cpunc_axi_sequencer.sv
// Randomized bench for cpunc_axi_sequencer with a cycle-level slave and a reference model of latency and lane rules.
module tb_cpunc_axi_sequencer;

   logic        clk;
   logic        rst_n;
   logic        req_valid, req_ready, req_we;
   logic [1:0]  req_size;
   logic [11:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid, rsp_err;
   logic [31:0] rsp_rdata;
   logic [11:0] CPUNC_AWADDR, CPUNC_ARADDR;
   logic        CPUNC_AWVALID, CPUNC_AWREADY, CPUNC_WVALID, CPUNC_WLAST, CPUNC_WREADY;
   logic [31:0] CPUNC_WDATA, CPUNC_RDATA;
   logic [3:0]  CPUNC_WSTRB;
   logic        CPUNC_BRESP, CPUNC_BVALID, CPUNC_BREADY;
   logic        CPUNC_ARVALID, CPUNC_ARREADY, CPUNC_RRESP, CPUNC_RVALID, CPUNC_RREADY;

   int checks = 0;
   int passes = 0;

   int          obs_wait, obs_rsp_cyc, obs_unstable, obs_busy_ready;
   logic        obs_ready_after, obs_rsp_after, obs_err, obs_saw_axi, obs_w_first;
   logic [31:0] obs_rdata, obs_wdata;
   logic [11:0] obs_araddr, obs_awaddr;
   logic [3:0]  obs_wstrb;

   cpunc_axi_sequencer #(.AXI_ADDR_WIDTH(12), .AXI_DATA_WIDTH(32)) dut (
      .CPUNC_ACLK(clk), .CPUNC_ARESETn(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .CPUNC_AWADDR(CPUNC_AWADDR), .CPUNC_AWVALID(CPUNC_AWVALID), .CPUNC_AWREADY(CPUNC_AWREADY),
      .CPUNC_WDATA(CPUNC_WDATA), .CPUNC_WSTRB(CPUNC_WSTRB), .CPUNC_WVALID(CPUNC_WVALID),
      .CPUNC_WLAST(CPUNC_WLAST), .CPUNC_WREADY(CPUNC_WREADY),
      .CPUNC_BRESP(CPUNC_BRESP), .CPUNC_BVALID(CPUNC_BVALID), .CPUNC_BREADY(CPUNC_BREADY),
      .CPUNC_ARADDR(CPUNC_ARADDR), .CPUNC_ARVALID(CPUNC_ARVALID), .CPUNC_ARREADY(CPUNC_ARREADY),
      .CPUNC_RDATA(CPUNC_RDATA), .CPUNC_RRESP(CPUNC_RRESP), .CPUNC_RVALID(CPUNC_RVALID),
      .CPUNC_RREADY(CPUNC_RREADY)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   function automatic logic model_mis(input logic [1:0] size, input logic [11:0] addr);
      if (size == 2'd3) return 1'b1;
      return (int'(addr[1:0]) % (1 << size)) != 0;
   endfunction

   function automatic logic [3:0] model_strb(input logic [1:0] size, input logic [11:0] addr);
      logic [3:0] s;
      int off, n;
      s = '0; off = int'(addr[1:0]); n = 1 << size;
      for (int i = 0; i < 4; i++) if (i >= off && i < off + n) s[i] = 1'b1;
      return s;
   endfunction

   function automatic logic [31:0] model_wdata(input logic [11:0] addr, input logic [31:0] d);
      logic [31:0] w;
      int off;
      w = '0; off = int'(addr[1:0]);
      for (int i = 0; i < 4; i++) if (i >= off) w[8*i +: 8] = d[8*(i-off) +: 8];
      return w;
   endfunction

   function automatic logic [31:0] model_rdata(input logic [1:0] size, input logic [11:0] addr,
                                               input logic [31:0] d);
      logic [31:0] r;
      int off, n;
      r = '0; off = int'(addr[1:0]); n = 1 << size;
      for (int j = 0; j < 4; j++) if (j < n) r[8*j +: 8] = d[8*(off+j) +: 8];
      return r;
   endfunction

   function automatic int model_latency(input logic we, input logic [1:0] size, input logic [11:0] addr,
                                        input int aw, input int w, input int b, input int ar, input int r);
      if (model_mis(size, addr)) return 2;
      if (!we) return 4 + ar + r;
`ifdef CPUNC_SEQ_AWW_PAR_EN
      return 4 + ((aw > w) ? aw : w) + b;
`else
      return 5 + aw + w + b;
`endif
   endfunction

   // ---------------- request driver and AXI slave ----------------
   task automatic clear_slave();
      CPUNC_AWREADY = 1'b0; CPUNC_WREADY = 1'b0; CPUNC_ARREADY = 1'b0;
      CPUNC_RVALID = 1'b0; CPUNC_RRESP = 1'b0; CPUNC_RDATA = '0;
      CPUNC_BVALID = 1'b0; CPUNC_BRESP = 1'b0;
   endtask

   task automatic run_txn(input logic we, input logic [1:0] size, input logic [11:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rdata, input logic resp,
                          input int aw_dly, input int w_dly, input int b_dly,
                          input int ar_dly, input int r_dly);
      int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
      logic pv_ar, pv_aw, pv_w, pr_ar, pr_aw, pr_w, w_hs;
      logic [11:0] p_araddr, p_awaddr;
      logic [31:0] p_wdata;
      logic [3:0]  p_wstrb;
      aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
      pv_ar = 0; pv_aw = 0; pv_w = 0; pr_ar = 0; pr_aw = 0; pr_w = 0; w_hs = 0;
      p_araddr = '0; p_awaddr = '0; p_wdata = '0; p_wstrb = '0;
      obs_rsp_cyc = -1; obs_unstable = 0; obs_busy_ready = 0; obs_ready_after = 0;
      obs_rsp_after = 1'b1; obs_err = 0; obs_saw_axi = 0; obs_w_first = 0; obs_rdata = '0;
      obs_araddr = '1; obs_awaddr = '1; obs_wdata = '0; obs_wstrb = '0;
      obs_wait = 0;
      while (!req_ready && obs_wait < 20) begin
         @(posedge clk); #1;
         obs_wait++;
      end
      req_valid = 1'b1; req_we = we; req_size = size; req_addr = addr; req_wdata = wdata;
      @(posedge clk); #1;
      req_valid = 1'b0; req_we = ~we; req_size = 2'($urandom);
      req_addr = 12'($urandom); req_wdata = $urandom;
      for (int cyc = 1; cyc < 60; cyc++) begin
         if (obs_rsp_cyc >= 0) begin
            obs_ready_after = req_ready;
            obs_rsp_after   = rsp_valid;
            break;
         end
         if (req_ready) obs_busy_ready++;
         if (CPUNC_ARVALID || CPUNC_AWVALID || CPUNC_WVALID) obs_saw_axi = 1'b1;
         if (CPUNC_WLAST !== CPUNC_WVALID) obs_unstable++;
         if (pv_ar && !pr_ar && (!CPUNC_ARVALID || CPUNC_ARADDR !== p_araddr)) obs_unstable++;
         if (pv_aw && !pr_aw && (!CPUNC_AWVALID || CPUNC_AWADDR !== p_awaddr)) obs_unstable++;
         if (pv_w && !pr_w && (!CPUNC_WVALID || CPUNC_WDATA !== p_wdata || CPUNC_WSTRB !== p_wstrb))
            obs_unstable++;
         if (w_hs && CPUNC_AWVALID && !CPUNC_WVALID) obs_w_first = 1'b1;
         if (rsp_valid) begin
            obs_rsp_cyc = cyc; obs_rdata = rsp_rdata; obs_err = rsp_err;
         end
         CPUNC_ARREADY = CPUNC_ARVALID && (ar_cnt >= ar_dly);
         if (CPUNC_ARVALID) begin
            if (CPUNC_ARREADY) obs_araddr = CPUNC_ARADDR;
            ar_cnt++;
         end
         CPUNC_AWREADY = CPUNC_AWVALID && (aw_cnt >= aw_dly);
         if (CPUNC_AWVALID) begin
            if (CPUNC_AWREADY) obs_awaddr = CPUNC_AWADDR;
            aw_cnt++;
         end
         CPUNC_WREADY = CPUNC_WVALID && (w_cnt >= w_dly);
         if (CPUNC_WVALID) begin
            if (CPUNC_WREADY) begin
               obs_wdata = CPUNC_WDATA; obs_wstrb = CPUNC_WSTRB; w_hs = 1'b1;
            end
            w_cnt++;
         end
         CPUNC_RVALID = CPUNC_RREADY && (r_cnt >= r_dly);
         CPUNC_RDATA  = CPUNC_RVALID ? rdata : $urandom;
         CPUNC_RRESP  = CPUNC_RVALID ? resp : 1'($urandom);
         if (CPUNC_RREADY) r_cnt++;
         CPUNC_BVALID = CPUNC_BREADY && (b_cnt >= b_dly);
         CPUNC_BRESP  = CPUNC_BVALID ? resp : 1'($urandom);
         if (CPUNC_BREADY) b_cnt++;
         pv_ar = CPUNC_ARVALID; pr_ar = CPUNC_ARREADY; p_araddr = CPUNC_ARADDR;
         pv_aw = CPUNC_AWVALID; pr_aw = CPUNC_AWREADY; p_awaddr = CPUNC_AWADDR;
         pv_w  = CPUNC_WVALID;  pr_w  = CPUNC_WREADY;  p_wdata = CPUNC_WDATA; p_wstrb = CPUNC_WSTRB;
         @(posedge clk); #1;
      end
      clear_slave();
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst_n = 1'b0; req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = '0; req_wdata = '0;
      clear_slave();
      repeat (2) @(posedge clk);
      #1;
      checks++; if (req_ready !== 1'b1) $display("FAIL reset_req_ready: got %b want 1", req_ready); else passes++;
      checks++;
      if ({rsp_valid, rsp_err, CPUNC_ARVALID, CPUNC_AWVALID, CPUNC_WVALID, CPUNC_WLAST, CPUNC_RREADY, CPUNC_BREADY} !== 8'h00)
         $display("FAIL reset_ctrl: got %b want 00000000",
                  {rsp_valid, rsp_err, CPUNC_ARVALID, CPUNC_AWVALID, CPUNC_WVALID, CPUNC_WLAST, CPUNC_RREADY, CPUNC_BREADY});
      else passes++;
      checks++;
      if ({rsp_rdata, CPUNC_WDATA, CPUNC_WSTRB, CPUNC_ARADDR, CPUNC_AWADDR} !== '0)
         $display("FAIL reset_data: rdata %h wdata %h wstrb %b araddr %h awaddr %h want all 0",
                  rsp_rdata, CPUNC_WDATA, CPUNC_WSTRB, CPUNC_ARADDR, CPUNC_AWADDR);
      else passes++;
      req_valid = 1'b0;
      rst_n = 1'b1;
      @(posedge clk); #1;
      checks++; if (req_ready !== 1'b1) $display("FAIL post_reset_ready: got %b want 1", req_ready); else passes++;
   endtask

   task automatic test_word_read();
      run_txn(1'b0, 2'd2, 12'h010, 32'h0, 32'hDEADBEEF, 1'b0, 0, 0, 0, 0, 0);
      checks++; if (obs_rsp_cyc != 4) $display("FAIL word_read_cycle: got %0d want 4", obs_rsp_cyc); else passes++;
      checks++; if (obs_araddr !== 12'h010) $display("FAIL word_read_araddr: got %h want 010", obs_araddr); else passes++;
      checks++; if (obs_rdata !== 32'hDEADBEEF) $display("FAIL word_read_data: got %h want deadbeef", obs_rdata); else passes++;
      checks++; if (obs_err !== 1'b0) $display("FAIL word_read_err: got %b want 0", obs_err); else passes++;
      checks++; if (obs_rsp_after !== 1'b0) $display("FAIL word_read_pulse: rsp_valid %b after pulse want 0", obs_rsp_after); else passes++;
      checks++; if (obs_ready_after !== 1'b1) $display("FAIL word_read_ready_back: got %b want 1", obs_ready_after); else passes++;
   endtask

   task automatic test_byte_read();
      run_txn(1'b0, 2'd0, 12'h013, 32'h0, 32'hA1B2C3D4, 1'b0, 0, 0, 0, 0, 0);
      checks++; if (obs_araddr !== 12'h010) $display("FAIL byte_read_araddr: got %h want 010", obs_araddr); else passes++;
      checks++; if (obs_rdata !== 32'h000000A1) $display("FAIL byte_read_data: got %h want 000000a1", obs_rdata); else passes++;
   endtask

   task automatic test_half_write_delayed();
      int lat;
      lat = model_latency(1'b1, 2'd1, 12'h022, 3, 0, 0, 0, 0);
      run_txn(1'b1, 2'd1, 12'h022, 32'h0000BEEF, 32'h0, 1'b0, 3, 0, 0, 0, 0);
      checks++; if (obs_awaddr !== 12'h020) $display("FAIL half_write_awaddr: got %h want 020", obs_awaddr); else passes++;
      checks++; if (obs_wstrb !== 4'b1100) $display("FAIL half_write_wstrb: got %b want 1100", obs_wstrb); else passes++;
      checks++; if (obs_wdata !== 32'hBEEF0000) $display("FAIL half_write_wdata: got %h want beef0000", obs_wdata); else passes++;
      checks++; if (obs_rsp_cyc != lat) $display("FAIL half_write_cycle: got %0d want %0d", obs_rsp_cyc, lat); else passes++;
      checks++; if (obs_unstable != 0) $display("FAIL half_write_stable: %0d payload/valid violations want 0", obs_unstable); else passes++;
      checks++; if (obs_rdata !== 32'h0) $display("FAIL half_write_rdata: got %h want 0", obs_rdata); else passes++;
   endtask

   task automatic test_misaligned();
      run_txn(1'b0, 2'd2, 12'h006, 32'h0, 32'h12345678, 1'b0, 0, 0, 0, 0, 0);
      checks++; if (obs_saw_axi !== 1'b0) $display("FAIL misaligned_axi: saw valid %b want 0", obs_saw_axi); else passes++;
      checks++; if (obs_rsp_cyc != 2) $display("FAIL misaligned_cycle: got %0d want 2", obs_rsp_cyc); else passes++;
      checks++; if (obs_err !== 1'b1) $display("FAIL misaligned_err: got %b want 1", obs_err); else passes++;
      checks++; if (obs_rdata !== 32'h0) $display("FAIL misaligned_rdata: got %h want 0", obs_rdata); else passes++;
   endtask

   task automatic test_bresp_err();
      run_txn(1'b1, 2'd2, 12'h100, 32'hCAFEF00D, 32'h0, 1'b1, 0, 0, 0, 0, 0);
      checks++; if (obs_err !== 1'b1) $display("FAIL bresp_err: got %b want 1", obs_err); else passes++;
      checks++; if (obs_wstrb !== 4'b1111) $display("FAIL bresp_wstrb: got %b want 1111", obs_wstrb); else passes++;
   endtask

   task automatic test_reset_mid_w();
      int n;
      int seen_rsp;
      logic reached;
      reached = 1'b0; seen_rsp = 0;
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_addr = 12'h040; req_wdata = $urandom;
      @(posedge clk); #1;
      req_valid = 1'b0;
      for (n = 0; n < 10; n++) begin
         if (CPUNC_WVALID) begin reached = 1'b1; break; end
         CPUNC_AWREADY = CPUNC_AWVALID;
         @(posedge clk); #1;
      end
      CPUNC_AWREADY = 1'b0;
      checks++; if (reached !== 1'b1) $display("FAIL rst_mid_reach_w: WVALID seen %b want 1", reached); else passes++;
      #2 rst_n = 1'b0;
      #1;
      checks++; if (CPUNC_WVALID !== 1'b0) $display("FAIL rst_mid_wvalid: got %b want 0", CPUNC_WVALID); else passes++;
      checks++; if (req_ready !== 1'b1) $display("FAIL rst_mid_ready: got %b want 1", req_ready); else passes++;
      checks++;
      if ({CPUNC_AWVALID, CPUNC_BREADY, CPUNC_WSTRB} !== 6'b0)
         $display("FAIL rst_mid_outputs: awvalid %b bready %b wstrb %b want 0", CPUNC_AWVALID, CPUNC_BREADY, CPUNC_WSTRB);
      else passes++;
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         if (rsp_valid) seen_rsp++;
         @(posedge clk); #1;
      end
      checks++; if (seen_rsp != 0) $display("FAIL rst_mid_no_rsp: got %0d responses want 0", seen_rsp); else passes++;
   endtask

   task automatic test_unsolicited();
      int bad;
      bad = 0;
      CPUNC_RVALID = 1'b1; CPUNC_RRESP = 1'b1; CPUNC_BVALID = 1'b1; CPUNC_BRESP = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         if (CPUNC_RREADY || CPUNC_BREADY || rsp_valid || !req_ready) bad++;
      end
      clear_slave();
      checks++; if (bad != 0) $display("FAIL unsolicited_ignored: got %0d bad cycles want 0", bad); else passes++;
   endtask

   task automatic test_back_to_back();
      run_txn(1'b1, 2'd0, 12'h201, 32'h0000005A, 32'h0, 1'b0, 0, 0, 0, 0, 0);
      run_txn(1'b0, 2'd1, 12'h202, 32'h0, 32'h87654321, 1'b0, 0, 0, 0, 0, 0);
      checks++; if (obs_wait != 0) $display("FAIL b2b_wait: got %0d idle waits want 0", obs_wait); else passes++;
      checks++; if (obs_rsp_cyc != 4) $display("FAIL b2b_cycle: got %0d want 4", obs_rsp_cyc); else passes++;
      checks++; if (obs_rdata !== 32'h00008765) $display("FAIL b2b_rdata: got %h want 00008765", obs_rdata); else passes++;
   endtask

`ifdef CPUNC_SEQ_AWW_PAR_EN
   task automatic test_aww_parallel();
      run_txn(1'b1, 2'd2, 12'h300, 32'h11223344, 32'h0, 1'b0, 2, 0, 1, 0, 0);
      checks++; if (obs_w_first !== 1'b1) $display("FAIL aww_w_first: got %b want 1", obs_w_first); else passes++;
      checks++; if (obs_rsp_cyc != 7) $display("FAIL aww_cycle: got %0d want 7", obs_rsp_cyc); else passes++;
      checks++; if (obs_unstable != 0) $display("FAIL aww_stable: got %0d violations want 0", obs_unstable); else passes++;
   endtask
`endif

   task automatic test_random();
      logic we, resp, mis;
      logic [1:0] sz;
      logic [11:0] addr;
      logic [31:0] wd, rd, exp_rd;
      int aw, w, b, ar, r, lat;
      for (int i = 0; i < 40; i++) begin
         we = 1'($urandom); sz = 2'($urandom); addr = 12'($urandom);
         wd = $urandom; rd = $urandom; resp = ($urandom_range(0, 3) == 0);
         aw = $urandom_range(0, 3); w = $urandom_range(0, 3); b = $urandom_range(0, 3);
         ar = $urandom_range(0, 3); r = $urandom_range(0, 3);
         mis = model_mis(sz, addr);
         lat = model_latency(we, sz, addr, aw, w, b, ar, r);
         exp_rd = (mis || we) ? 32'h0 : model_rdata(sz, addr, rd);
         run_txn(we, sz, addr, wd, rd, resp, aw, w, b, ar, r);
         checks++; if (obs_rsp_cyc != lat) $display("FAIL rand_cycle[%0d]: got %0d want %0d", i, obs_rsp_cyc, lat); else passes++;
         checks++; if (obs_err !== (mis | resp)) $display("FAIL rand_err[%0d]: got %b want %b", i, obs_err, mis | resp); else passes++;
         checks++; if (obs_rdata !== exp_rd) $display("FAIL rand_rdata[%0d]: got %h want %h", i, obs_rdata, exp_rd); else passes++;
         checks++; if (obs_saw_axi !== !mis) $display("FAIL rand_axi_traffic[%0d]: got %b want %b", i, obs_saw_axi, !mis); else passes++;
         checks++;
         if (obs_unstable != 0 || obs_busy_ready != 0 || obs_ready_after !== 1'b1)
            $display("FAIL rand_protocol[%0d]: unstable %0d busy_ready %0d ready_after %b want 0 0 1",
                     i, obs_unstable, obs_busy_ready, obs_ready_after);
         else passes++;
         if (!mis && !we) begin
            checks++; if (obs_araddr !== {addr[11:2], 2'b00}) $display("FAIL rand_araddr[%0d]: got %h want %h", i, obs_araddr, {addr[11:2], 2'b00}); else passes++;
         end
         if (!mis && we) begin
            checks++; if (obs_awaddr !== {addr[11:2], 2'b00}) $display("FAIL rand_awaddr[%0d]: got %h want %h", i, obs_awaddr, {addr[11:2], 2'b00}); else passes++;
            checks++; if (obs_wstrb !== model_strb(sz, addr)) $display("FAIL rand_wstrb[%0d]: got %b want %b", i, obs_wstrb, model_strb(sz, addr)); else passes++;
            checks++; if (obs_wdata !== model_wdata(addr, wd)) $display("FAIL rand_wdata[%0d]: got %h want %h", i, obs_wdata, model_wdata(addr, wd)); else passes++;
         end
      end
   endtask

   initial begin
      test_reset();
      test_word_read();
      test_byte_read();
      test_half_write_delayed();
      test_misaligned();
      test_bresp_err();
      test_reset_mid_w();
      test_unsolicited();
      test_back_to_back();
`ifdef CPUNC_SEQ_AWW_PAR_EN
      test_aww_parallel();
`endif
      test_random();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
